prbs_chk: RTL
=============

PRBS_CHK -- requirements
Module: prbs_chk

Interface
REQ-001 LOCK_N, 4, consecutive correct predictions in HUNT required to declare lock (range 1..15).
REQ-002 LOSS_N, 3, consecutive mismatches in LOCK required to drop lock (range 1..15).
REQ-003 c  input  1  clock; all state updates on rising edge.
REQ-004 rn  input  1  reset, asynchronous, active-low.
REQ-005 v  input  1  data valid; d is sampled only on edges where v=1.
REQ-006 d  input  4  received word from the upstream 4-bit LFSR source.
REQ-007 clr  input  1  synchronous clear of the error counter.
REQ-008 lock  output  1  registered; 1 while in LOCK state.
REQ-009 err  output  1  registered one-cycle pulse per mismatching word in LOCK.
REQ-010 ecnt  output  8  registered saturating error count.
REQ-011 zd  output  1  registered sticky all-zero-word flag (see Configuration).

Function
REQ-012 Successor function f(x) SHALL be {x[0]^x[1], x[3], x[2], x[1]}; period-15 sequence from 4'hf: f,7,3,1,8,4,2,9,c,6,b,5,a,d,e,f.
REQ-013 Register p SHALL capture d on every v=1 edge; flag pv SHALL set on the first such capture and stay set until reset.
REQ-014 FSM states SHALL be HUNT and LOCK; reset state HUNT.
REQ-015 HUNT, v=1, pv=1: d==f(p) -> hit+1, else hit=0; v=1 with pv=0 leaves hit unchanged.
REQ-016 HUNT -> LOCK on the edge where the increment brings hit to LOCK_N; same edge loads ref <= f(d), miss <= 0.
REQ-017 LOCK, v=1: compare d with ref; ref <= f(ref) regardless of result (received data SHALL NOT reseed ref).
REQ-018 LOCK match -> miss=0; mismatch -> err=1 on the following cycle, ecnt+1 saturating at 8'hff, miss+1.
REQ-019 LOCK -> HUNT on the edge where miss reaches LOSS_N; hit <= 0; that word's err pulse and ecnt increment SHALL still occur.
REQ-020 v=0 edges SHALL hold all state (p, ref, hit, miss, FSM); err=0.
REQ-021 err and ecnt increment SHALL never occur in HUNT.
REQ-022 clr=1 SHALL set ecnt to 0 on that edge; clr wins over a simultaneous increment.
REQ-023 lock SHALL change on the same edge as the FSM transition (latency 1 from the deciding word).

Reset
REQ-024 rn=0 SHALL immediately force: state HUNT, lock=0, err=0, ecnt=0, zd=0, p=0, pv=0, ref=0, hit=0, miss=0.
REQ-025 Reset asserted mid-LOCK SHALL discard lock; after release, lock requires a full LOCK_N reacquisition.

Configuration
REQ-026 Macro PRBS_CHK_ZERO_DET_EN defined: a v=1 word d==4'h0 in any state SHALL set zd (sticky until reset), force HUNT with hit=0, miss=0, and produce no err pulse or ecnt increment.
REQ-027 Macro undefined: zd SHALL be tied 0 and d==4'h0 SHALL be treated as ordinary data under REQ-015..019.

Verification
REQ-028 Reset, then v=1 stream f,7,3,1,8 -> lock=1 the cycle after 8 is sampled; err=0, ecnt=0 throughout.
REQ-029 Locked at ...,8,4; send 4,2? no: send 2 replaced by 3, then 9,c -> exactly one err pulse, ecnt=1, lock stays 1 (ref continues 9,c).
REQ-030 Locked; send three consecutive wrong words (0x5,0x5,0x5 in place of 2,9,c) -> three err pulses, ecnt=3, lock=0 after the third.
REQ-031 Force 256 mismatches while locked (LOSS_N=15, interleave correct words) -> ecnt saturates at 8'hff; clr asserted with a mismatch same edge -> ecnt=0.
REQ-032 Stream with v toggling 1/0 every cycle, correct sequence -> lock after 5 valid words; gaps change nothing.
REQ-033 With PRBS_CHK_ZERO_DET_EN, locked, inject d=0 -> zd=1, lock=0, no err, ecnt unchanged; without macro, same stimulus -> zd=0, err pulse, ecnt+1.

Source files
------------

// File: rtl/prbs_chk_if.sv
// Stream bus between a 4-bit PRBS source and the prbs_chk checker.
// The master drives valid data and clear; the checker (slave) reports its lock and error status.
interface prbs_chk_if;
   logic       v;
   logic [3:0] d;
   logic       clr;
   logic       lock;
   logic       err;
   logic [7:0] ecnt;
   logic       zd;

   modport master (
      output v,
      output d,
      output clr,
      input  lock,
      input  err,
      input  ecnt,
      input  zd
   );

   modport slave (
      input  v,
      input  d,
      input  clr,
      output lock,
      output err,
      output ecnt,
      output zd
   );
endinterface

// File: rtl/prbs_chk.sv
// Lock-tracking checker for a 4-bit LFSR stream. HUNT learns the sequence, and LOCK free-runs a reference and counts errors.
// Optional feature: define PRBS_CHK_ZERO_DET_EN to flag the illegal all-zero word (sticky zd) and force re-hunt.
module prbs_chk #(
   parameter int unsigned LOCK_N = 4,
   parameter int unsigned LOSS_N = 3
) (
   input  logic       c,
   input  logic       rn,
   prbs_chk_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   localparam logic [4:0] LOCK_N_W = 5'(LOCK_N);
   localparam logic [4:0] LOSS_N_W = 5'(LOSS_N);

   // LFSR successor: shift right, feedback taps x[0]^x[1] enter at the MSB.
   function automatic logic [3:0] prbs_next(input logic [3:0] x);
      return {x[0] ^ x[1], x[3], x[2], x[1]};
   endfunction

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_p;
   logic [3:0]  w_p_nxt;
   logic        r_pv;
   logic        w_pv_nxt;
   logic [3:0]  r_ref;
   logic [3:0]  w_ref_nxt;
   logic [3:0]  r_hit;
   logic [3:0]  w_hit_nxt;
   logic [3:0]  r_miss;
   logic [3:0]  w_miss_nxt;
   logic        r_lock;
   logic        r_err;
   logic        w_err_nxt;
   logic        w_ecnt_inc;
   logic [7:0]  r_ecnt;
   logic [7:0]  w_ecnt_nxt;
   logic [4:0]  w_hit_inc;
   logic [4:0]  w_miss_inc;
   logic        w_zero;

   assign w_hit_inc  = {1'b0, r_hit} + 5'd1;
   assign w_miss_inc = {1'b0, r_miss} + 5'd1;

`ifdef PRBS_CHK_ZERO_DET_EN
   logic r_zd;

   assign w_zero = bus.v & (bus.d == 4'h0);

   // Sticky all-zero flag; only reset clears it.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         r_zd <= 1'b0;
      end else if (w_zero) begin
         r_zd <= 1'b1;
      end else begin
         r_zd <= r_zd;
      end
   end

   assign bus.zd = r_zd;
`else
   assign w_zero = 1'b0;
   assign bus.zd = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and tracking logic; an invalid word leaves everything untouched.
   always_comb begin
      w_state_nxt = r_state;
      w_p_nxt     = r_p;
      w_pv_nxt    = r_pv;
      w_ref_nxt   = r_ref;
      w_hit_nxt   = r_hit;
      w_miss_nxt  = r_miss;
      w_err_nxt   = 1'b0;
      w_ecnt_inc  = 1'b0;
      if (bus.v) begin
         w_p_nxt  = bus.d;
         w_pv_nxt = 1'b1;
         if (w_zero) begin
            w_state_nxt = ST_HUNT;
            w_hit_nxt   = 4'h0;
            w_miss_nxt  = 4'h0;
         end else begin
            case (r_state)
               ST_HUNT: begin
                  if (!r_pv) begin
                     w_hit_nxt = r_hit;
                  end else if (bus.d == prbs_next(r_p)) begin
                     w_hit_nxt = w_hit_inc[3:0];
                     if (w_hit_inc == LOCK_N_W) begin
                        w_state_nxt = ST_LOCK;
                        w_ref_nxt   = prbs_next(bus.d);
                        w_miss_nxt  = 4'h0;
                     end else begin
                        w_state_nxt = ST_HUNT;
                     end
                  end else begin
                     w_hit_nxt = 4'h0;
                  end
               end
               ST_LOCK: begin
                  // The reference free-runs; received data never reseeds it.
                  w_ref_nxt = prbs_next(r_ref);
                  if (bus.d == r_ref) begin
                     w_miss_nxt = 4'h0;
                  end else begin
                     w_err_nxt  = 1'b1;
                     w_ecnt_inc = 1'b1;
                     w_miss_nxt = w_miss_inc[3:0];
                     if (w_miss_inc == LOSS_N_W) begin
                        w_state_nxt = ST_HUNT;
                        w_hit_nxt   = 4'h0;
                     end else begin
                        w_state_nxt = ST_LOCK;
                     end
                  end
               end
               default: begin
                  w_state_nxt = ST_HUNT;
                  w_hit_nxt   = 4'h0;
                  w_miss_nxt  = 4'h0;
               end
            endcase
         end
      end else begin
         w_err_nxt = 1'b0;
      end
   end

   // Error counter: clear dominates, increment saturates at all-ones.
   always_comb begin
      w_ecnt_nxt = r_ecnt;
      if (bus.clr) begin
         w_ecnt_nxt = 8'h00;
      end else if (w_ecnt_inc && (r_ecnt != 8'hff)) begin
         w_ecnt_nxt = r_ecnt + 8'h01;
      end else begin
         w_ecnt_nxt = r_ecnt;
      end
   end

   // Tracking datapath registers.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         r_p    <= 4'h0;
         r_pv   <= 1'b0;
         r_ref  <= 4'h0;
         r_hit  <= 4'h0;
         r_miss <= 4'h0;
      end else begin
         r_p    <= w_p_nxt;
         r_pv   <= w_pv_nxt;
         r_ref  <= w_ref_nxt;
         r_hit  <= w_hit_nxt;
         r_miss <= w_miss_nxt;
      end
   end

   // Registered status outputs; lock follows the FSM transition edge.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         r_lock <= 1'b0;
         r_err  <= 1'b0;
         r_ecnt <= 8'h00;
      end else begin
         r_lock <= (w_state_nxt == ST_LOCK);
         r_err  <= w_err_nxt;
         r_ecnt <= w_ecnt_nxt;
      end
   end

   assign bus.lock = r_lock;
   assign bus.err  = r_err;
   assign bus.ecnt = r_ecnt;

endmodule
